mips_mc_control: RTL

- Multicycle control FSM for the MIPS processor.
- It is the initiating end of the ALU interface: it sequences each instruction through fetch, decode, execute, memory and writeback, and drives the ALU operation code and operand selects every cycle.
- It consumes the ALU zero flag and the memory ready handshake.
- It sits between the instruction register (op/funct fields) and the datapath muxes and write enables.

---
 rtl/mips_mc_control.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects. Optional macro ILLEGAL_TRAP_EN makes illegal ops halt.
module mips_mc_control #(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter int         MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic [2:0] aluControl,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       immZeroExt,
  output logic [1:0] pcSrc,
  output logic       pcEn,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       memTimeout,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    IMM_EX   = 4'd9,
    IMM_WB   = 4'd10,
    JUMP     = 4'd11,
    ILLEGAL  = 4'd12
  } stateT;

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  stateT         r_state;
  stateT         w_nextState;
  logic [CW-1:0] r_waitCnt;
  logic          w_waiting;
  logic          w_timeoutHit;
  logic          w_functOk;
  logic [2:0]    w_functAlu;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= stateT'(RESET_STATE);
    else          r_state <= w_nextState;
  end

  // Count consecutive stalled memory cycles; the pulse fires on the limit-th one.
  assign w_waiting    = ((r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR)) && !memReady;
  assign w_timeoutHit = (MEM_WAIT_MAX != 0) && w_waiting && (r_waitCnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n)          r_waitCnt <= '0;
    else if (!w_waiting)   r_waitCnt <= '0;
    else if (w_timeoutHit) r_waitCnt <= '0;
    else                   r_waitCnt <= r_waitCnt + CW'(1);
  end

  assign memTimeout = w_timeoutHit && reset_n;
  assign state      = r_state;

`ifdef ILLEGAL_TRAP_EN
  assign halted = (r_state == ILLEGAL);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    w_functOk  = 1'b1;
    w_functAlu = 3'd0;
    case (funct)
      6'h20:   w_functAlu = 3'd0;
      6'h22:   w_functAlu = 3'd1;
      6'h24:   w_functAlu = 3'd2;
      6'h25:   w_functAlu = 3'd3;
      6'h27:   w_functAlu = 3'd4;
      6'h2A:   w_functAlu = 3'd5;
      6'h00:   w_functAlu = 3'd6;
      6'h02:   w_functAlu = 3'd7;
      default: w_functOk  = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:    if (memReady) w_nextState = DECODE;
      DECODE: begin
        case (op)
          6'h23, 6'h2B:        w_nextState = MEMADR;
          6'h00:               w_nextState = RTYPE_EX;
          6'h04, 6'h05:        w_nextState = BRANCH;
          6'h08, 6'h0C, 6'h0D: w_nextState = IMM_EX;
          6'h02:               w_nextState = JUMP;
          default:             w_nextState = ILLEGAL;
        endcase
      end
      MEMADR:   w_nextState = (op == 6'h23) ? MEMRD : MEMWR;
      MEMRD:    if (memReady) w_nextState = MEMWB;
      MEMWR:    if (memReady) w_nextState = FETCH;
      RTYPE_EX: w_nextState = w_functOk ? ALUWB : ILLEGAL;
      IMM_EX:   w_nextState = IMM_WB;
`ifdef ILLEGAL_TRAP_EN
      ILLEGAL:  w_nextState = ILLEGAL;
`else
      ILLEGAL:  w_nextState = FETCH;
`endif
      default:  w_nextState = FETCH;
    endcase
  end

  always_comb begin
    aluControl = 3'd0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    immZeroExt = 1'b0;
    pcSrc      = 2'b00;
    pcEn       = 1'b0;
    iorD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    case (r_state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcEn    = memReady;
      end
      DECODE:   aluSrcB = 2'b11;
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      RTYPE_EX: begin
        aluSrcA    = 1'b1;
        aluControl = w_functAlu;
      end
      ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = 3'd1;
        pcSrc      = 2'b01;
        pcEn       = (op == 6'h04) ? zero : !zero;
      end
      IMM_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        if (op == 6'h0C) begin
          aluControl = 3'd2;
          immZeroExt = 1'b1;
        end else if (op == 6'h0D) begin
          aluControl = 3'd3;
          immZeroExt = 1'b1;
        end
      end
      IMM_WB:   regWrite = 1'b1;
      JUMP: begin
        pcSrc = 2'b10;
        pcEn  = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts any in-flight access or write in the same cycle.
    if (!reset_n) begin
      pcEn     = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
    end
  end

endmodule
